ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//  Execute stage; sits between the ID/EX pipeline register and the MEM stage.
//  - Selects forwarded operands from its own EX/MEM register or from WB.
//  - Runs the WISC ALU and keeps the Z/V/N flag register.
//  - Registers the EX/MEM outputs, which feed data memory and writeback.
//  - Honours stall (hold) and flush (bubble) from the hazard unit.
// PARAMETERS
//  DW        16   datapath width; only 16 is supported
//  RW        4    register index width
// PORTS
//  clk              in   1    core clock; all state updates on rising edge
//  rst_n            in   1    synchronous, active-low reset
//  EX_PCPlus2       in   16   PC+2 of the instruction in EX
//  EX_SrcData1      in   16   register-file read data for rs
//  EX_SrcData2      in   16   register-file read data for rt
//  EX_ImmOperand    in   16   immediate, already extended/shifted by ID
//  EX_SrcReg1       in   4    rs index
//  EX_SrcReg2       in   4    rt index
//  EX_RegDst        in   4    rd index
//  EX_Opcode        in   4    WISC opcode
//  EX_RegWrite      in   1    instruction writes a register
//  EX_ALUSrcSel1    in   1    1: operand A = PCPlus2; 0: forwarded rs
//  EX_ALUSrcSel2    in   1    1: operand B = immediate; 0: forwarded rt
//  EX_StoreInstr    in   1    instruction is SW
//  EX_MemToReg      in   1    instruction is LW
//  WB_RegWrite      in   1    WB stage writes the register file
//  WB_RegDst        in   4    WB destination index
//  WB_WriteData     in   16   WB write data
//  WEN              in   1    0: stall; hold all state
//  Flush            in   1    1: load a bubble into EX/MEM
//  MEM_ALUOut       out  16   registered ALU result / memory address
//  MEM_StoreData    out  16   registered forwarded rt, used by SW
//  MEM_RegDst       out  4    registered rd
//  MEM_RegWrite     out  1    registered RegWrite
//  MEM_StoreInstr   out  1    registered StoreInstr
//  MEM_MemToReg     out  1    registered MemToReg
//  Flags            out  3    {Z,V,N}; feeds branch resolution in ID
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): all outputs and Flags go to 0. Reset overrides
//   WEN and Flush and takes effect mid-stall.
//  Latency: 1 cycle. EX inputs at edge k appear on the MEM_* outputs after
//   edge k; a flag update is visible after the same edge.
//  Forwarding, per source s (rs, rt), highest priority first:
//   - EX/MEM: MEM_RegWrite & ~MEM_MemToReg & MEM_RegDst==s & s!=0 -> MEM_ALUOut
//   - WB: WB_RegWrite & WB_RegDst==s & s!=0 -> WB_WriteData
//   - otherwise: register-file data
//   - The hazard unit stalls load-use cases; this block does not detect them.
//  ALU, A=operand A, B=operand B:
//   ADD 0000 / SUB 0001: signed result, saturates to 7FFF/8000; V=1 on saturation.
//   XOR 0010: A^B.
//   RED 0011: sign-extend((A[15:8]+B[15:8]) + (A[7:0]+B[7:0])), 8-bit byte sums.
//   SLL 0100 / SRA 0101 / ROR 0110: shift A by B[3:0].
//   PADDSB 0111: four independent 4-bit signed saturating adds.
//   LW 1000 / SW 1001: (A+B) & FFFE.
//   LLB 1010: (A & FF00) | B[7:0].
//   LHB 1011: (A & 00FF) | (B[7:0]<<8).
//   PCS 1110: A (PCPlus2).
//   B 1100 / BR 1101 / HLT 1111: result 0; control bits pass unchanged.
//  Flags:
//   - ADD and SUB write Z, V and N.
//   - XOR, SLL, SRA and ROR write Z only; V and N hold.
//   - All other opcodes hold all flags.
//   - N = result[15] after saturation.
//  Stall and flush:
//   - WEN=0: hold EX/MEM and Flags. Stall wins over Flush.
//   - WEN=1 & Flush=1: RegWrite, StoreInstr and MemToReg load 0; data fields
//     are don't-care; Flags hold.
// STRUCTURE
//  Shared package wisc_pkg: opcode localparams (OP_ADD..OP_HLT), FLAG_Z/V/N
//   bit indices.
//  Sub-module ex_alu: combinational ALU; outputs result, zero, ovf and neg.
//  ex_stage holds the forwarding muxes, Flags, the EX/MEM dff bank and
//   stall/flush gating.
// TESTING
//  1. ADD 7000+2000, operands from register file -> MEM_ALUOut=7FFF, Flags=Z0 V1 N0.
//  2. Back-to-back writes to R3; next instr reads R3 while WB also writes R3=1111 ->
//     MEM_ALUOut value is forwarded, not 1111.
//  3. SUB 5-5 -> Z=1; then LLB -> Flags stay 101? no: Flags stay {1,0,0}.
//  4. WEN=0 for 3 cycles with changing inputs -> all outputs and Flags frozen.
//  5. Flush with ADD R1 in EX -> MEM_RegWrite=0 and Flags unchanged; R0 as
//     destination is never forwarded.
//  6. rst_n=0 during a stall -> all outputs 0 after the next edge;
//     PADDSB 7777+1111 -> 7777.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcode encodings and bit positions within the {Z,V,N} flag vector.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/ex_alu.sv
// Combinational WISC ALU. Produces the result together with the zero, overflow and negative
// indications; the caller decides which of these indications update the flag register.
module ex_alu
  import wisc_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  op,
  output logic [15:0] result,
  output logic        zero,
  output logic        ovf,
  output logic        neg
);

  logic [15:0] b_eff;
  logic [16:0] sum17;
  logic        sum_ovf;
  logic [15:0] sum_sat;
  logic [7:0]  red_hi;
  logic [7:0]  red_lo;
  logic [8:0]  red_sum;
  logic [31:0] rot;
  logic [15:0] paddsb;
  logic [4:0]  nib;
  logic [15:0] addr;

  always_comb begin
    // SUB is A + ~B + 1, using a 17-bit sign-extended sum to detect saturation
    b_eff   = (op == OP_SUB) ? ~b : b;
    sum17   = {a[15], a} + {b_eff[15], b_eff} + {16'b0, (op == OP_SUB)};
    sum_ovf = sum17[16] ^ sum17[15];
    sum_sat = sum_ovf ? (sum17[16] ? 16'h8000 : 16'h7fff) : sum17[15:0];

    red_hi  = a[15:8] + b[15:8];
    red_lo  = a[7:0] + b[7:0];
    red_sum = {red_hi[7], red_hi} + {red_lo[7], red_lo};

    rot  = {a, a} >> b[3:0];
    addr = (a + b) & 16'hfffe;

    paddsb = '0;
    nib    = '0;
    for (int i = 0; i < 4; i++) begin
      nib = {a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]};
      if (nib[4] != nib[3]) paddsb[4*i +: 4] = nib[4] ? 4'h8 : 4'h7;
      else                  paddsb[4*i +: 4] = nib[3:0];
    end

    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = sum_sat;
        ovf    = sum_ovf;
      end
      OP_XOR:       result = a ^ b;
      OP_RED:       result = {{7{red_sum[8]}}, red_sum};
      OP_SLL:       result = a << b[3:0];
      OP_SRA:       result = $signed(a) >>> b[3:0];
      OP_ROR:       result = rot[15:0];
      OP_PADDSB:    result = paddsb;
      OP_LW, OP_SW: result = addr;
      OP_LLB:       result = (a & 16'hff00) | {8'h00, b[7:0]};
      OP_LHB:       result = (a & 16'h00ff) | {b[7:0], 8'h00};
      OP_PCS:       result = a;
      default:      result = '0;
    endcase
    zero = (result == 16'h0000);
    neg  = result[15];
  end

endmodule

// File: rtl/ex_stage.sv
// WISC execute stage: operand forwarding, ALU, Z/V/N flag register and the EX/MEM pipeline
// register, with stall and flush control from the hazard unit.
module ex_stage
  import wisc_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] EX_PCPlus2,
  input  logic [DW-1:0] EX_SrcData1,
  input  logic [DW-1:0] EX_SrcData2,
  input  logic [DW-1:0] EX_ImmOperand,
  input  logic [RW-1:0] EX_SrcReg1,
  input  logic [RW-1:0] EX_SrcReg2,
  input  logic [RW-1:0] EX_RegDst,
  input  logic [3:0]    EX_Opcode,
  input  logic          EX_RegWrite,
  input  logic          EX_ALUSrcSel1,
  input  logic          EX_ALUSrcSel2,
  input  logic          EX_StoreInstr,
  input  logic          EX_MemToReg,
  input  logic          WB_RegWrite,
  input  logic [RW-1:0] WB_RegDst,
  input  logic [DW-1:0] WB_WriteData,
  input  logic          WEN,
  input  logic          Flush,
  output logic [DW-1:0] MEM_ALUOut,
  output logic [DW-1:0] MEM_StoreData,
  output logic [RW-1:0] MEM_RegDst,
  output logic          MEM_RegWrite,
  output logic          MEM_StoreInstr,
  output logic          MEM_MemToReg,
  output logic [2:0]    Flags
);

  logic [DW-1:0] alu_out_q, alu_out_d;
  logic [DW-1:0] store_data_q, store_data_d;
  logic [RW-1:0] reg_dst_q, reg_dst_d;
  logic          reg_write_q, reg_write_d;
  logic          store_instr_q, store_instr_d;
  logic          mem_to_reg_q, mem_to_reg_d;
  logic [2:0]    flags_q, flags_d;

  logic [DW-1:0] fwd1, fwd2, op_a, op_b, alu_result;
  logic          alu_zero, alu_ovf, alu_neg, mem_fwd_ok;

  ex_alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (EX_Opcode),
    .result (alu_result),
    .zero   (alu_zero),
    .ovf    (alu_ovf),
    .neg    (alu_neg)
  );

  // A load's EX/MEM ALUOut is an address, not the loaded value, so it never forwards.
  always_comb begin
    mem_fwd_ok = reg_write_q && !mem_to_reg_q;
    fwd1 = EX_SrcData1;
    if (WB_RegWrite && WB_RegDst == EX_SrcReg1 && EX_SrcReg1 != '0) fwd1 = WB_WriteData;
    if (mem_fwd_ok && reg_dst_q == EX_SrcReg1 && EX_SrcReg1 != '0) fwd1 = alu_out_q;
    fwd2 = EX_SrcData2;
    if (WB_RegWrite && WB_RegDst == EX_SrcReg2 && EX_SrcReg2 != '0) fwd2 = WB_WriteData;
    if (mem_fwd_ok && reg_dst_q == EX_SrcReg2 && EX_SrcReg2 != '0) fwd2 = alu_out_q;
    op_a = EX_ALUSrcSel1 ? EX_PCPlus2 : fwd1;
    op_b = EX_ALUSrcSel2 ? EX_ImmOperand : fwd2;
  end

  // WEN=0 holds everything (stall beats flush); WEN=1 with Flush=1 loads a bubble whose
  // control bits are zero and leaves the flags untouched.
  always_comb begin
    alu_out_d     = alu_out_q;
    store_data_d  = store_data_q;
    reg_dst_d     = reg_dst_q;
    reg_write_d   = reg_write_q;
    store_instr_d = store_instr_q;
    mem_to_reg_d  = mem_to_reg_q;
    flags_d       = flags_q;
    if (WEN) begin
      alu_out_d     = alu_result;
      store_data_d  = fwd2;
      reg_dst_d     = EX_RegDst;
      reg_write_d   = EX_RegWrite && !Flush;
      store_instr_d = EX_StoreInstr && !Flush;
      mem_to_reg_d  = EX_MemToReg && !Flush;
      if (!Flush) begin
        case (EX_Opcode)
          OP_ADD, OP_SUB: begin
            flags_d[FLAG_Z] = alu_zero;
            flags_d[FLAG_V] = alu_ovf;
            flags_d[FLAG_N] = alu_neg;
          end
          OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[FLAG_Z] = alu_zero;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out_q     <= '0;
      store_data_q  <= '0;
      reg_dst_q     <= '0;
      reg_write_q   <= 1'b0;
      store_instr_q <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      flags_q       <= '0;
    end else begin
      alu_out_q     <= alu_out_d;
      store_data_q  <= store_data_d;
      reg_dst_q     <= reg_dst_d;
      reg_write_q   <= reg_write_d;
      store_instr_q <= store_instr_d;
      mem_to_reg_q  <= mem_to_reg_d;
      flags_q       <= flags_d;
    end
  end

  assign MEM_ALUOut     = alu_out_q;
  assign MEM_StoreData  = store_data_q;
  assign MEM_RegDst     = reg_dst_q;
  assign MEM_RegWrite   = reg_write_q;
  assign MEM_StoreInstr = store_instr_q;
  assign MEM_MemToReg   = mem_to_reg_q;
  assign Flags          = flags_q;

endmodule
